// File: rtl/diff_drive_ramp.sv
// diff_drive_ramp: differential-drive wheel speed ramp with steering mix, brake and post-brake hold.
module diff_drive_ramp #(
   parameter int W        = 7,
   parameter int STEP     = 1,
   parameter int TICK_DIV = 1000,
   parameter int BRK_HOLD = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] in_acc,
   input  logic [W:0]   in_ste,
   input  logic         in_valid,
   input  logic         brk,
   output logic [W-1:0] v_l,
   output logic [W-1:0] v_r,
   output logic         settled,
   output logic [1:0]   state
);
   typedef enum logic [1:0] {IDLE, RUN, BRAKE, HOLD} state_t;
   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int HW = (BRK_HOLD > 0) ? $clog2(BRK_HOLD + 1) : 1;
   localparam logic [W-1:0]  STEP_V    = W'(STEP);
   localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(BRK_HOLD - 1);

   state_t         st, st_n;
   logic [CW-1:0]  cnt, cnt_n;
   logic [HW-1:0]  hold_cnt, hold_n;
   logic [W-1:0]   tgt_l, tgt_r, eff_l, eff_r, new_l, new_r, trim, vl_n, vr_n;
   logic [W:0]     mag;
   logic           ste_pos, active, tick, settled_n;

   function automatic logic [W-1:0] toward(input logic [W-1:0] v, input logic [W-1:0] t);
      return (v < t) ? ((t - v > STEP_V) ? v + STEP_V : t)
                     : ((v - t > STEP_V) ? v - STEP_V : t);
   endfunction

   // Magnitude is W+1 bits wide so the most negative steering still yields a full-width magnitude.
   always_comb begin
      mag     = in_ste[W] ? -in_ste : in_ste;
      ste_pos = !in_ste[W] && |in_ste;
      trim    = ({1'b0, in_acc} < mag) ? '0 : in_acc - mag[W-1:0];
      new_l   = ste_pos ? trim : in_acc;
      new_r   = in_ste[W] ? trim : in_acc;
      eff_l   = in_valid ? new_l : tgt_l;
      eff_r   = in_valid ? new_r : tgt_r;
      active  = (st == RUN) || (st == HOLD);
      tick    = active && (cnt == TICK_LAST);
   end

   always_comb begin
      st_n = st;
      case (st)
         IDLE:    if (in_valid) st_n = RUN;
         BRAKE:   st_n = HOLD;
         HOLD:    if (tick && hold_cnt == HOLD_LAST) st_n = RUN;
         default: st_n = st;
      endcase
      if (brk) st_n = BRAKE;
   end

   // Outputs are forced to zero whenever the next state is not RUN; this gives the
   // one-cycle brake response with no ramp down.
   always_comb begin
      vl_n      = (st_n != RUN) ? '0 : (st == RUN && tick) ? toward(v_l, eff_l) : v_l;
      vr_n      = (st_n != RUN) ? '0 : (st == RUN && tick) ? toward(v_r, eff_r) : v_r;
      settled_n = (st_n == RUN) && (vl_n == eff_l) && (vr_n == eff_r);
      cnt_n     = brk ? '0 : !active ? cnt : tick ? '0 : cnt + CW'(1);
      hold_n    = (st_n != HOLD) ? '0 : tick ? hold_cnt + HW'(1) : hold_cnt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st       <= IDLE;
         cnt      <= '0;
         hold_cnt <= '0;
         tgt_l    <= '0;
         tgt_r    <= '0;
         v_l      <= '0;
         v_r      <= '0;
         settled  <= 1'b0;
      end else begin
         st       <= st_n;
         cnt      <= cnt_n;
         hold_cnt <= hold_n;
         tgt_l    <= eff_l;
         tgt_r    <= eff_r;
         v_l      <= vl_n;
         v_r      <= vr_n;
         settled  <= settled_n;
      end
   end

   assign state = st;
endmodule
